// File: rtl/rv_pkg.sv
// Shared RV32I definitions: datapath width, register count and ABI register indices.
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_ZERO  = 0;

  localparam int REG_RA = 1;
  localparam int REG_SP = 2;
  localparam int REG_GP = 3;
  localparam int REG_TP = 4;
  localparam int REG_T0 = 5;
  localparam int REG_T1 = 6;
  localparam int REG_T2 = 7;
  localparam int REG_S0 = 8;
  localparam int REG_S1 = 9;
  localparam int REG_A0 = 10;
  localparam int REG_A1 = 11;
  localparam int REG_A7 = 17;
  localparam int REG_S2 = 18;
  localparam int REG_S11 = 27;
  localparam int REG_T3 = 28;
  localparam int REG_T6 = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for decode hazard detection, with an incrementally tracked pending count.
module regfile_scoreboard import rv_pkg::*; #(
  parameter  int DEPTH    = REG_COUNT,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             clr_valid,
  input  logic [AW-1:0]    clr_rd,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      pending_count
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic             inc;
  logic             dec;

  // One-hot decode over legal indices only, so out-of-range addresses never match.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_vec[i] = issue_valid && (issue_rd == AW'(i)) && !((ZERO_REG != 0) && (i == REG_ZERO));
      clr_vec[i] = clr_valid && (clr_rd == AW'(i));
    end
  end

  // A set on the same index overrides the clear, so that clear never decrements.
  assign inc = |(set_vec & ~busy);
  assign dec = |(clr_vec & busy & ~set_vec);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= (busy & ~clr_vec) | set_vec;
      pending_count <= pending_count + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port integer register file with optional hardwired zero, write bypass and busy scoreboard.
module regfile_mp_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   addr_rs,
  output logic [NUM_RD*XLEN-1:0] data_rs,
  output logic [NUM_RD-1:0]      busy_rs,
  input  logic [AW-1:0]          addr_rd,
  input  logic [XLEN-1:0]        data_rd,
  input  logic                   write_enable,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic [AW:0]            pending_count
);
  import rv_pkg::*;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] busy;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = write_enable && (addr_rd == AW'(i)) && !((ZERO_REG != 0) && (i == REG_ZERO));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) mem[i] <= data_rd;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .clr_valid     (write_enable),
    .clr_rd        (addr_rd),
    .busy          (busy),
    .pending_count (pending_count)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] mem_word;
    logic            hit;
    logic            busy_bit;
    logic            fwd;
    logic            zero_sel;

    assign addr = addr_rs[p*AW +: AW];

    always_comb begin
      mem_word = '0;
      hit      = 1'b0;
      busy_bit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == AW'(i)) begin
          mem_word = mem[i];
          hit      = 1'b1;
          busy_bit = busy[i];
        end
      end
    end

    // Forwarding is suppressed under reset so reads go to zero immediately.
    assign zero_sel = !hit || ((ZERO_REG != 0) && (addr == AW'(REG_ZERO)));
    assign fwd      = (BYPASS != 0) && write_enable && !reset && (addr_rd == addr);

    assign data_rs[p*XLEN +: XLEN] = zero_sel ? '0 : (fwd ? data_rd : mem_word);
    assign busy_rs[p]              = hit && busy_bit && !fwd;
  end

endmodule
